// File: rtl/gray_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module      : gray_stream_monitor
// Description : Decodes a Gray-coded sample stream to binary, classifies each
//               step against the previous sample, counts illegal steps.
// Revision    : 1.0
// ============================================================================
module gray_stream_monitor #(
    parameter int N     = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray_in,
    input  logic             gray_valid,
    input  logic             resync,
    input  logic             clear_err,
    output logic [N-1:0]     binary_out,
    output logic             binary_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             step_hold,
    output logic             step_err,
    output logic             tracking,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t         state;
    logic [N-1:0]   prev_bin;
    logic [N-1:0]   dec_bin;
    logic [N-1:0]   prev_plus;
    logic [N-1:0]   prev_minus;
    logic           is_hold;
    logic           is_up;
    logic           is_down;
    logic           classify;
    logic           err_event;

    // Each binary bit is the parity of all Gray bits at or above it.
    for (genvar i = 0; i < N; i++) begin : g_dec
        assign dec_bin[i] = ^gray_in[N-1:i];
    end

    assign prev_plus  = prev_bin + N'(1);
    assign prev_minus = prev_bin - N'(1);
    assign is_hold    = (dec_bin == prev_bin);
    assign is_up      = (dec_bin == prev_plus);
    assign is_down    = (dec_bin == prev_minus);

    // A resync sample is treated as the first one, so it is never classified.
    assign classify   = gray_valid && (state == TRACK) && !resync;
    assign err_event  = classify && !is_hold && !is_up && !is_down;

    assign tracking   = (state == TRACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EMPTY;
            prev_bin     <= '0;
            binary_out   <= '0;
            binary_valid <= 1'b0;
            step_up      <= 1'b0;
            step_down    <= 1'b0;
            step_hold    <= 1'b0;
            step_err     <= 1'b0;
            err_count    <= '0;
        end else begin
            binary_valid <= gray_valid;
            step_hold    <= classify && is_hold;
            step_up      <= classify && !is_hold && is_up;
            step_down    <= classify && !is_hold && !is_up && is_down;
            step_err     <= err_event;

            if (gray_valid) begin
                binary_out <= dec_bin;
                prev_bin   <= dec_bin;
                state      <= TRACK;
            end else if (resync) begin
                state      <= EMPTY;
            end

            if (clear_err) begin
                err_count <= err_event ? ERR_W'(1) : '0;
            end else if (err_event && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_stream_monitor
// Description : Scoreboard bench for gray_stream_monitor (N=8, ERR_W=2).
// Revision    : 1.0
// ============================================================================
module tb_gray_stream_monitor;

    localparam int N     = 8;
    localparam int ERR_W = 2;

    typedef struct {
        logic [N-1:0] bin;
        logic [3:0]   flags;   // {up, down, hold, err}
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     gray_in;
    logic             gray_valid;
    logic             resync;
    logic             clear_err;
    logic [N-1:0]     binary_out;
    logic             binary_valid;
    logic             step_up;
    logic             step_down;
    logic             step_hold;
    logic             step_err;
    logic             tracking;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    exp_t         sb[$];
    logic         m_track;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_out;
    int           m_err;

    gray_stream_monitor #(.N(N), .ERR_W(ERR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .gray_in      (gray_in),
        .gray_valid   (gray_valid),
        .resync       (resync),
        .clear_err    (clear_err),
        .binary_out   (binary_out),
        .binary_valid (binary_valid),
        .step_up      (step_up),
        .step_down    (step_down),
        .step_hold    (step_hold),
        .step_err     (step_err),
        .tracking     (tracking),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b = g;
        for (int i = 1; i < N; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle, update the model, then check outputs 1 ns after the edge.
    task automatic cycle(input logic rst, input logic v, input logic [N-1:0] g,
                         input logic rs, input logic ce);
        exp_t         e;
        logic [N-1:0] d;
        logic         is_err;
        logic [3:0]   obs_flags;
        reset = rst; gray_valid = v; gray_in = g; resync = rs; clear_err = ce;
        is_err = 1'b0;
        if (rst) begin
            m_track = 1'b0; m_prev = '0; m_out = '0; m_err = 0;
            sb.delete();
        end else begin
            if (v) begin
                d       = g2b(g);
                e.bin   = d;
                e.flags = 4'b0000;
                if (m_track && !rs) begin
                    if (d == m_prev)                 e.flags = 4'b0010;
                    else if (d == N'(m_prev + 1))    e.flags = 4'b1000;
                    else if (d == N'(m_prev - 1))    e.flags = 4'b0100;
                    else begin e.flags = 4'b0001; is_err = 1'b1; end
                end
                sb.push_back(e);
                m_track = 1'b1; m_prev = d; m_out = d;
            end else if (rs) begin
                m_track = 1'b0;
            end
            if (ce)          m_err = is_err ? 1 : 0;
            else if (is_err) m_err = (m_err < (1 << ERR_W) - 1) ? m_err + 1 : m_err;
        end
        @(posedge clk);
        #1;
        obs_flags = {step_up, step_down, step_hold, step_err};
        if (binary_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("flags", obs_flags, e.flags);
            end
        end else begin
            if (sb.size() != 0) begin
                check_val("missing_valid", 0, 1);
                void'(sb.pop_front());
            end
            check_val("idle_flags", obs_flags, 0);
        end
        check_val("binary_out", binary_out, m_out);
        check_val("tracking", tracking, m_track);
        check_val("err_count", err_count, m_err);
    endtask

    initial begin
        reset = 1'b1; gray_valid = 1'b0; gray_in = '0; resync = 1'b0; clear_err = 1'b0;
        m_track = 1'b0; m_prev = '0; m_out = '0; m_err = 0;
        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        check_val("reset_valid", binary_valid, 0);

        // Counting up from reset
        cycle(0, 1, 8'h00, 0, 0);
        cycle(0, 1, 8'h01, 0, 0);
        cycle(0, 1, 8'h03, 0, 0);
        cycle(0, 1, 8'h02, 0, 0);
        check_val("count_to_3", binary_out, 3);

        // Wrap up and down
        cycle(0, 1, 8'h80, 1, 0);
        cycle(0, 1, 8'h00, 0, 0);
        check_val("wrap_up", {binary_out, step_up}, {8'd0, 1'b1});
        cycle(0, 1, 8'h80, 0, 0);
        check_val("wrap_down", {binary_out, step_down}, {8'd255, 1'b1});

        // Illegal step then hold
        cycle(0, 1, 8'h00, 1, 0);
        cycle(0, 1, 8'h02, 0, 0);
        check_val("err_first", {step_err, 8'(err_count)}, {1'b1, 8'd1});
        cycle(0, 1, 8'h02, 0, 0);
        check_val("hold_after_err", {step_hold, 8'(err_count)}, {1'b1, 8'd1});
        cycle(0, 0, 8'h00, 0, 1);

        // Saturation and clear behaviour
        cycle(0, 1, b2g(8'd0), 1, 0);
        for (int k = 1; k <= 5; k++) cycle(0, 1, b2g(8'(3 * k)), 0, 0);
        check_val("saturated", err_count, 3);
        cycle(0, 1, b2g(8'd18), 0, 1);
        check_val("clear_with_err", err_count, 1);
        cycle(0, 0, 8'h00, 0, 1);
        check_val("clear_alone", err_count, 0);

        // Gaps and resync
        cycle(0, 1, 8'h07, 1, 0);
        check_val("resync_bin", binary_out, 5);
        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h05, 0, 0);
        check_val("after_resync_up", {binary_out, step_up}, {8'd6, 1'b1});
        cycle(0, 0, 8'h00, 1, 0);
        check_val("resync_idle_track", tracking, 0);
        cycle(0, 1, 8'h05, 0, 0);

        // Mixed random walk with gaps
        begin
            logic [N-1:0] b = 8'd100;
            for (int k = 0; k < 60; k++) begin
                int r = $urandom_range(0, 9);
                if (r < 3)      b = b + 1;
                else if (r < 6) b = b - 1;
                else if (r < 8) b = b;
                else            b = 8'($urandom);
                cycle(0, ($urandom_range(0, 3) != 0), b2g(b),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0));
            end
        end

        // Reset mid-stream with a sample present
        cycle(1, 1, 8'h33, 0, 0);
        check_val("midreset_zero", {binary_out, tracking, binary_valid}, 0);
        cycle(0, 1, 8'h01, 0, 0);
        check_val("post_reset_first", {binary_out, step_up, step_down, step_hold, step_err}, {8'd1, 4'b0});
        cycle(0, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_stream_monitor.md
Name: gray_stream_monitor

Overview:
- Consumes a stream of N-bit Gray-coded samples, such as the output of the binary-to-Gray converter stage or a Gray position counter.
- Decodes each sample to binary and classifies the step from the previous sample as hold, up, down or error.
- Keeps a saturating count of illegal steps.
- Sits directly downstream of the Gray encoder. Feeds position-tracking logic and status registers.

Parameters:
- N, 8, width of Gray input and binary output
- ERR_W, 8, width of saturating error counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- gray_in  input  N  Gray-coded sample
- gray_valid  input  1  gray_in valid this cycle
- resync  input  1  discard reference sample; next valid sample re-seeds
- clear_err  input  1  clear err_count
- binary_out  output  N  registered decoded value of last accepted sample
- binary_valid  output  1  one-cycle pulse, binary_out/step flags updated
- step_up  output  1  last step was +1 mod 2^N
- step_down  output  1  last step was -1 mod 2^N
- step_hold  output  1  last step was 0
- step_err  output  1  last step was illegal
- tracking  output  1  reference sample held (state TRACK)
- err_count  output  ERR_W  saturating count of illegal steps

Behaviour:
- Reset: the following are synchronous and apply on the clk edge while reset=1.
  - binary_out=0, binary_valid=0, all step_* = 0, tracking=0, err_count=0.
  - State goes to EMPTY; internal prev_bin=0.
- Decode: bin[N-1]=gray[N-1]; bin[i]=bin[i+1]^gray[i]. Purely combinational ahead of the output register.
- Latency: 1 clk from gray_valid to binary_valid/binary_out/step_*.
- All step_* and binary_valid are registered and high for exactly one cycle per accepted sample. At most one step_* is high.
- No backpressure: every gray_valid cycle is accepted.
- State EMPTY (tracking=0), on gray_valid:
  - binary_out=decode, binary_valid=1, all step_*=0 (no reference).
  - prev_bin=decode; go to TRACK.
- State TRACK (tracking=1), on gray_valid with d=decode:
  - d==prev_bin gives step_hold.
  - d==prev_bin+1 mod 2^N gives step_up (255->0 is up for N=8).
  - d==prev_bin-1 mod 2^N gives step_down (0->255 is down).
  - Anything else gives step_err, and err_count increments.
  - In all cases binary_out=d and prev_bin=d; the sample becomes the new reference even on error.
- No gray_valid: binary_valid and step_* deassert next cycle. binary_out, prev_bin and state hold.
- resync=1: state goes to EMPTY next edge, tracking=0.
  - If gray_valid is also high that cycle, the sample is decoded and output with no step flags, and becomes the reference. State ends in TRACK.
  - Net effect: that sample is treated as the first sample.
- err_count:
  - Saturates at 2^ERR_W-1; further errors keep step_err pulsing but do not wrap.
  - clear_err alone sets it to 0.
  - clear_err together with a same-cycle error sets it to 1.
- Reset mid-stream: a sample presented in the reset cycle is discarded. The first valid sample after reset releases behaves as in EMPTY.

Test Plan:
- Reset, then gray_in=0x00,0x01,0x03,0x02 on consecutive valid cycles:
  - binary_out 0,1,2,3.
  - First sample: no step flag. Next three: step_up.
  - tracking=1 from cycle 2.
- Seed 0x80 (bin 255), then 0x00, then 0x80:
  - 0x00 gives step_up, binary_out=0 (wrap).
  - 0x80 gives step_down, binary_out=255.
- Seed 0x00, then 0x02 (bin 3), then 0x02:
  - 0x02 gives step_err, err_count=1.
  - Repeated 0x02 gives step_hold, err_count stays 1.
- With ERR_W=2, drive 5 illegal steps:
  - err_count goes 1,2,3,3,3.
  - clear_err together with a 6th error gives err_count=1.
  - clear_err alone gives 0.
- Gaps and resync:
  - Valid samples separated by idle cycles: binary_valid pulses once per sample, outputs hold during gaps.
  - resync together with gray_in=0x07: binary_out=5, no step flag.
  - Next 0x05 (bin 6) gives step_up.
- Reset mid-stream:
  - Assert reset with gray_valid high: outputs zero, tracking=0, err_count=0, sample ignored.
  - First post-reset sample produces no step flag.
